// File: rtl/vdp_pkg.sv
// Shared encodings for the VDP command sequencer: op codes, FSM states,
// high-byte prefixes for control-port words and the byte selection helper.
package vdp_pkg;

    localparam logic [2:0] OP_REG_WR    = 3'd0;
    localparam logic [2:0] OP_SET_WADDR = 3'd1;
    localparam logic [2:0] OP_SET_RADDR = 3'd2;
    localparam logic [2:0] OP_DATA_WR   = 3'd3;
    localparam logic [2:0] OP_DATA_RD   = 3'd4;
    localparam logic [2:0] OP_STAT_RD   = 3'd5;

    localparam logic [7:0] REG_WR_PREFIX = 8'h80;
    localparam logic [1:0] WADDR_PREFIX  = 2'b01;
    localparam logic [1:0] RADDR_PREFIX  = 2'b00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WPULSE = 3'd1,
        WGAP   = 3'd2,
        RHOLD  = 3'd3,
        RGAP   = 3'd4
    } vdp_state_e;

    // Byte to drive for a write op; 'second' picks the high/control byte.
    function automatic logic [7:0] byte_sel(input logic [2:0] op, input logic [13:0] arg,
                                            input logic [7:0] data, input logic second);
        byte_sel = data;
        case (op)
            OP_REG_WR:    byte_sel = second ? (REG_WR_PREFIX | {5'd0, arg[2:0]}) : data;
            OP_SET_WADDR: byte_sel = second ? {WADDR_PREFIX, arg[13:8]} : arg[7:0];
            OP_SET_RADDR: byte_sel = second ? {RADDR_PREFIX, arg[13:8]} : arg[7:0];
            default:      byte_sel = data;
        endcase
    endfunction

endpackage

// File: rtl/vdp_port_timer.sv
// 4-bit load/count-down timer; done is high while the count sits at zero.
module vdp_port_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == 4'd0);

endmodule

// File: rtl/vdp_cmd_seq.sv
// Turns high-level VDP commands into strobed byte transfers on the VDP port.
// Handshake: a command is taken on a clk edge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE out of reset.
module vdp_cmd_seq
    import vdp_pkg::*;
#(
    parameter int WR_GAP  = 2,
    parameter int RD_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [13:0] cmd_arg,
    input  logic [7:0]  cmd_data,
    input  logic [7:0]  cmd_len,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        cmd_err,
    output logic        vdp_mode,
    output logic [7:0]  vdp_addr,
    output logic [7:0]  vdp_data_in,
    output logic        vdp_wr,
    output logic        vdp_rd,
    input  logic [15:0] vdp_data_out,
    output vdp_state_e  dbg_state
);

    localparam logic [3:0] GAP_LOAD  = 4'(WR_GAP - 1);
    localparam logic [3:0] HOLD_LOAD = 4'(RD_HOLD - 1);

    vdp_state_e  state;
    logic [2:0]  op_q;
    logic [13:0] arg_q;
    logic [7:0]  data_q;
    logic [8:0]  cnt;
    logic        tmr_load;
    logic [3:0]  tmr_val;
    logic        tmr_done;
    logic        is_read;
    logic        unused_low;

    assign unused_low = ^vdp_data_out[7:0];
    assign cmd_ready  = (state == IDLE) && reset;
    assign vdp_addr   = 8'h00;
    assign dbg_state  = state;
    assign is_read    = (cmd_op == OP_DATA_RD) || (cmd_op == OP_STAT_RD);

    // Timer reload points: entry into every multi-cycle state.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = GAP_LOAD;
        case (state)
            IDLE: begin
                tmr_load = cmd_valid;
                tmr_val  = is_read ? HOLD_LOAD : 4'd0;
            end
            WPULSE: tmr_load = 1'b1;
            RHOLD:  tmr_load = tmr_done;
            RGAP: begin
                tmr_load = tmr_done;
                tmr_val  = HOLD_LOAD;
            end
            default: ;
        endcase
    end

    vdp_port_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_q        <= 3'd0;
            arg_q       <= 14'd0;
            data_q      <= 8'd0;
            cnt         <= 9'd0;
            vdp_wr      <= 1'b0;
            vdp_rd      <= 1'b0;
            vdp_mode    <= 1'b0;
            vdp_data_in <= 8'd0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'd0;
            cmd_err     <= 1'b0;
        end else begin
            vdp_wr    <= 1'b0;
            vdp_rd    <= 1'b0;
            rsp_valid <= 1'b0;
            cmd_err   <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    op_q   <= cmd_op;
                    arg_q  <= cmd_arg;
                    data_q <= cmd_data;
                    case (cmd_op)
                        OP_REG_WR, OP_SET_WADDR, OP_SET_RADDR: begin
                            cnt         <= 9'd2;
                            state       <= WPULSE;
                            vdp_wr      <= 1'b1;
                            vdp_mode    <= 1'b1;
                            vdp_data_in <= byte_sel(cmd_op, cmd_arg, cmd_data, 1'b0);
                        end
                        OP_DATA_WR: begin
                            cnt         <= {1'b0, cmd_len} + 9'd1;
                            state       <= WPULSE;
                            vdp_wr      <= 1'b1;
                            vdp_mode    <= 1'b0;
                            vdp_data_in <= cmd_data;
                        end
                        OP_DATA_RD: begin
                            cnt      <= {1'b0, cmd_len} + 9'd1;
                            state    <= RHOLD;
                            vdp_rd   <= 1'b1;
                            vdp_mode <= 1'b0;
                        end
                        OP_STAT_RD: begin
                            cnt      <= 9'd1;
                            state    <= RHOLD;
                            vdp_rd   <= 1'b1;
                            vdp_mode <= 1'b1;
                        end
                        default: begin
                            // Illegal op: one dead cycle in WGAP with no strobe, then back to IDLE.
                            cnt     <= 9'd0;
                            state   <= WGAP;
                            cmd_err <= 1'b1;
                        end
                    endcase
                end
                WPULSE: begin
                    cnt   <= cnt - 9'd1;
                    state <= WGAP;
                end
                WGAP: if (tmr_done) begin
                    if (cnt == 9'd0) begin
                        state <= IDLE;
                    end else begin
                        state       <= WPULSE;
                        vdp_wr      <= 1'b1;
                        vdp_data_in <= byte_sel(op_q, arg_q, data_q, 1'b1);
                    end
                end
                RHOLD: begin
                    if (tmr_done) begin
                        cnt       <= cnt - 9'd1;
                        rsp_data  <= vdp_data_out[15:8];
                        rsp_valid <= 1'b1;
                        state     <= RGAP;
                    end else begin
                        vdp_rd <= 1'b1;
                    end
                end
                RGAP: if (tmr_done) begin
                    if (cnt == 9'd0) begin
                        state <= IDLE;
                    end else begin
                        state  <= RHOLD;
                        vdp_rd <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_cmd_seq.sv
// Directed bench for vdp_cmd_seq against a small VDP port model (address latch, VRAM, registers, status).
module tb_vdp_cmd_seq;
    import vdp_pkg::*;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [13:0] cmd_arg;
    logic [7:0]  cmd_data;
    logic [7:0]  cmd_len;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        cmd_err;
    logic        vdp_mode;
    logic [7:0]  vdp_addr;
    logic [7:0]  vdp_data_in;
    logic        vdp_wr;
    logic        vdp_rd;
    logic [15:0] vdp_data_out;
    vdp_state_e  dbg_state;

    vdp_cmd_seq dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_arg      (cmd_arg),
        .cmd_data     (cmd_data),
        .cmd_len      (cmd_len),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .cmd_err      (cmd_err),
        .vdp_mode     (vdp_mode),
        .vdp_addr     (vdp_addr),
        .vdp_data_in  (vdp_data_in),
        .vdp_wr       (vdp_wr),
        .vdp_rd       (vdp_rd),
        .vdp_data_out (vdp_data_out),
        .dbg_state    (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VDP port model
    logic [7:0]  vram [0:16383];
    logic [7:0]  vregs [0:7];
    logic [13:0] vaddr = 14'd0;
    logic [7:0]  vlatch = 8'd0;
    logic        vsecond = 1'b0;
    logic        rd_prev = 1'b0;
    logic        rd_mode_prev = 1'b0;
    logic [7:0]  status_reg;

    assign vdp_data_out = {(vdp_mode ? status_reg : vram[vaddr]), 8'h00};

    always @(posedge clk) begin
        if (vdp_wr) begin
            if (vdp_mode) begin
                if (!vsecond) begin
                    vlatch  = vdp_data_in;
                    vsecond = 1'b1;
                end else begin
                    vsecond = 1'b0;
                    if (vdp_data_in[7:6] == 2'b10) vregs[vdp_data_in[2:0]] = vlatch;
                    else vaddr = {vdp_data_in[5:0], vlatch};
                end
            end else begin
                vram[vaddr] = vdp_data_in;
                vaddr = vaddr + 14'd1;
            end
        end
        if (vdp_rd && vdp_mode) vsecond = 1'b0;
        if (rd_prev && !vdp_rd && !rd_mode_prev) vaddr = vaddr + 14'd1;
        rd_prev      = vdp_rd;
        rd_mode_prev = vdp_mode;
    end

    // monitor and scoreboard
    logic [8:0] exp_q [$];
    logic [8:0] wr_log [$];
    int wr_cnt, rd_cyc, rsp_cnt, wr_mode1, wr_nonzero;
    int overlap_cnt = 0;
    int wr_double = 0;
    logic wr_prev = 1'b0;
    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always @(negedge clk) begin
        if (vdp_wr) begin
            wr_cnt++;
            wr_log.push_back({vdp_mode, vdp_data_in});
            if (vdp_mode) wr_mode1++;
            if (vdp_data_in != 8'h00) wr_nonzero++;
        end
        if (vdp_rd) rd_cyc++;
        if (rsp_valid) rsp_cnt++;
        if (vdp_wr && vdp_rd) overlap_cnt++;
        if (vdp_wr && wr_prev) wr_double++;
        wr_prev = vdp_wr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_cnt = 0; rd_cyc = 0; rsp_cnt = 0; wr_mode1 = 0; wr_nonzero = 0;
        wr_log.delete();
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, wr_log.size(), exp_q.size());
        while (exp_q.size() > 0 && wr_log.size() > 0) check(tag, wr_log.pop_front(), exp_q.pop_front());
        exp_q.delete();
        wr_log.delete();
    endtask

    // driver
    task automatic send(input logic [2:0] op, input logic [13:0] arg, input logic [7:0] data,
                        input logic [7:0] len);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_data = data; cmd_len = len;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", cmd_ready, 1'b1);
    endtask

    logic [7:0] wr_v, rd_v, rdy_v, rsp_v;

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 14'd0; cmd_data = 8'd0; cmd_len = 8'd0;
        status_reg = 8'h80;
        clear_mon();

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_wr", vdp_wr, 1'b0);
        check("rst_rd", vdp_rd, 1'b0);
        check("rst_mode", vdp_mode, 1'b0);
        check("rst_data_in", vdp_data_in, 8'h00);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_addr", vdp_addr, 8'h00);
        check("rst_state", dbg_state, IDLE);
        reset = 1'b1;
        #1 check("rel_ready", cmd_ready, 1'b1);

        // REG_WR r1 = EA: pulses at cycles 1 and 4, ready back at cycle 7
        clear_mon();
        send(OP_REG_WR, 14'd1, 8'hEA, 8'd0);
        wr_v = 8'd0; rdy_v = 8'd0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            wr_v[c]  = vdp_wr;
            rdy_v[c] = cmd_ready;
            if (c == 1) begin
                check("regwr_mode0", vdp_mode, 1'b1);
                check("regwr_byte0", vdp_data_in, 8'hEA);
            end
            if (c == 4) begin
                check("regwr_mode1", vdp_mode, 1'b1);
                check("regwr_byte1", vdp_data_in, 8'h81);
            end
        end
        check("regwr_wr_pattern", wr_v, 8'h12);
        check("regwr_ready_pattern", rdy_v, 8'h80);
        exp_q.push_back({1'b1, 8'hEA});
        exp_q.push_back({1'b1, 8'h81});
        check_log("regwr_log");
        check("regwr_model_r1", vregs[1], 8'hEA);

        // illegal op 6
        clear_mon();
        send(3'd6, 14'd0, 8'h00, 8'd0);
        @(negedge clk);
        check("ill_err", cmd_err, 1'b1);
        check("ill_ready_c1", cmd_ready, 1'b0);
        @(negedge clk);
        check("ill_ready_c2", cmd_ready, 1'b1);
        check("ill_err_c2", cmd_err, 1'b0);
        check("ill_strobes", wr_cnt + rd_cyc, 0);

        // STAT_RD with status 80
        clear_mon();
        send(OP_STAT_RD, 14'd0, 8'h00, 8'd0);
        rd_v = 8'd0; rsp_v = 8'd0; rdy_v = 8'd0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            rd_v[c]  = vdp_rd;
            rsp_v[c] = rsp_valid;
            rdy_v[c] = cmd_ready;
            if (c == 2) check("stat_mode", vdp_mode, 1'b1);
        end
        check("stat_rd_pattern", rd_v, 8'h1E);
        check("stat_rsp_pattern", rsp_v, 8'h20);
        check("stat_ready_pattern", rdy_v, 8'h80);
        check("stat_rsp_data", rsp_data, 8'h80);
        check("stat_rsp_cnt", rsp_cnt, 1);

        // address set, write, read back
        clear_mon();
        send(OP_SET_WADDR, 14'h1234, 8'h00, 8'd0);
        send(OP_DATA_WR, 14'h0000, 8'h5A, 8'd0);
        send(OP_SET_RADDR, 14'h1234, 8'h00, 8'd0);
        send(OP_DATA_RD, 14'h0000, 8'h00, 8'd0);
        wait_idle(100);
        exp_q.push_back({1'b1, 8'h34});
        exp_q.push_back({1'b1, 8'h52});
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b1, 8'h34});
        exp_q.push_back({1'b1, 8'h12});
        check_log("seq_log");
        check("seq_rsp_cnt", rsp_cnt, 1);
        check("seq_rsp_data", rsp_data, 8'h5A);

        // 256-byte fill
        clear_mon();
        send(OP_DATA_WR, 14'h0000, 8'h00, 8'd255);
        wait_idle(1000);
        check("fill_wr_cnt", wr_cnt, 256);
        check("fill_mode1", wr_mode1, 0);
        check("fill_nonzero", wr_nonzero, 0);
        check("fill_state", dbg_state, IDLE);

        // reset mid-command
        clear_mon();
        send(OP_SET_WADDR, 14'h3FFF, 8'h00, 8'd0);
        @(negedge clk);
        check("rstmid_first_pulse", vdp_wr, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid_wr", vdp_wr, 1'b0);
        check("rstmid_rd", vdp_rd, 1'b0);
        check("rstmid_mode", vdp_mode, 1'b0);
        check("rstmid_data_in", vdp_data_in, 8'h00);
        check("rstmid_state", dbg_state, IDLE);
        check("rstmid_ready", cmd_ready, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_mon();
        repeat (10) @(negedge clk);
        check("rstmid_no_second", wr_cnt, 0);
        send(OP_STAT_RD, 14'd0, 8'h00, 8'd0);
        wait_idle(50);
        clear_mon();
        send(OP_REG_WR, 14'd7, 8'hF4, 8'd0);
        wait_idle(50);
        exp_q.push_back({1'b1, 8'hF4});
        exp_q.push_back({1'b1, 8'h87});
        check_log("post_rst_log");
        check("post_rst_model_r7", vregs[7], 8'hF4);

        // global strobe rules
        check("wr_rd_overlap", overlap_cnt, 0);
        check("wr_back_to_back", wr_double, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vdp_cmd_seq.md
VDP_CMD_SEQ -- requirements
Module: vdp_cmd_seq

Interface
REQ-001 SHALL have parameter WR_GAP, default 2, giving the number of idle cycles after every wr pulse (legal range 1-15).
REQ-002 SHALL have parameter RD_HOLD, default 4, giving the number of cycles rd is held per read (legal range 1-15).
REQ-003 SHALL use one clock and an asynchronous, active-low reset; ports are named clk and reset (reset asserted = 0).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-008 cmd_op  in  3  0 REG_WR, 1 SET_WADDR, 2 SET_RADDR, 3 DATA_WR, 4 DATA_RD, 5 STAT_RD, 6-7 illegal.
REQ-009 cmd_arg  in  14  VRAM address (SET_*), or register number in [2:0] (REG_WR).
REQ-010 cmd_data  in  8  register value (REG_WR) or fill byte (DATA_WR).
REQ-011 cmd_len  in  8  repeat count minus 1 (DATA_WR, DATA_RD); ignored otherwise.
REQ-012 rsp_valid  out  1  one-cycle pulse, read byte valid.
REQ-013 rsp_data  out  8  read byte, held until the next rsp_valid.
REQ-014 cmd_err  out  1  one-cycle pulse on acceptance of an illegal op.
REQ-015 vdp_mode  out  1  1 = register/status port, 0 = VRAM data port.
REQ-016 vdp_addr  out  8  constant 8'h00.
REQ-017 vdp_data_in  out  8  byte driven to the VDP.
REQ-018 vdp_wr  out  1  write strobe.
REQ-019 vdp_rd  out  1  read strobe.
REQ-020 vdp_data_out  in  16  VDP read data; bits [15:8] are sampled.

Function
REQ-021 SHALL implement FSM states IDLE, WPULSE, WGAP, RHOLD, RGAP; cmd_ready = (state==IDLE).
REQ-022 On acceptance, SHALL latch the op, arg, data and len, and SHALL load a byte counter (cmd_len+1 for DATA_*, 2 for REG_WR/SET_*, 1 for STAT_RD).
REQ-023 Byte sequences SHALL be as follows.
- REG_WR: mode 1, bytes {cmd_data, 8'h80|arg[2:0]}.
- SET_WADDR: mode 1, bytes {arg[7:0], 2'b01,arg[13:8]}.
- SET_RADDR: mode 1, bytes {arg[7:0], 2'b00,arg[13:8]}.
- DATA_WR: mode 0, cmd_data repeated cmd_len+1 times.
REQ-024 Write timing SHALL be WPULSE (wr=1) for exactly 1 cycle, then WGAP (wr=0) for WR_GAP cycles, then the next byte or IDLE; the first WPULSE SHALL occur the cycle after acceptance.
REQ-025 vdp_mode and vdp_data_in SHALL change only on transitions into WPULSE or RHOLD, and SHALL be stable throughout each strobe.
REQ-026 Reads (DATA_RD mode 0, cmd_len+1 reads; STAT_RD mode 1, 1 read) SHALL be RHOLD (rd=1) for RD_HOLD cycles, with vdp_data_out[15:8] sampled at the last RHOLD edge, then RGAP (rd=0) for WR_GAP cycles.
REQ-027 rsp_valid SHALL pulse in the first RGAP cycle of each read.
REQ-028 A REG_WR command SHALL occupy 2*(1+WR_GAP) cycles after acceptance; cmd_ready SHALL reassert in the following cycle (cycle 7 with defaults).
REQ-029 cmd_len=255 SHALL produce exactly 256 transfers; the counter SHALL NOT wrap early.
REQ-030 An illegal op SHALL be accepted, SHALL pulse cmd_err the next cycle, SHALL produce no strobe, and SHALL return to IDLE.
REQ-031 wr and rd SHALL never be high in the same cycle, and each strobe SHALL be followed by at least 1 low cycle.
REQ-032 cmd_valid held high SHALL yield back-to-back commands with no extra idle cycle beyond the IDLE acceptance cycle.

Reset
REQ-033 Reset assertion SHALL immediately force vdp_wr=0, vdp_rd=0, rsp_valid=0, cmd_err=0, state=IDLE and counters=0.
REQ-034 Reset values SHALL be vdp_mode=0, vdp_data_in=0, rsp_data=0; cmd_ready SHALL be 0 while reset is asserted and 1 after release.
REQ-035 A command interrupted by reset SHALL be discarded; the requester SHALL issue STAT_RD afterwards to resynchronise the VDP address latch.

Structure
REQ-036 Package vdp_pkg SHALL hold the op encodings, the FSM state enum, and the REG_WR/SET_WADDR/SET_RADDR high-byte prefixes (8'h80, 2'b01, 2'b00).
REQ-037 One sub-module vdp_port_timer (4-bit load/count-down, done flag) SHALL time both WR_GAP and RD_HOLD.

Verification
REQ-038 REG_WR arg=1, data=EA -> two 1-cycle wr pulses, mode=1, data EA then 81, 2 gap cycles each; cmd_ready back at cycle 7.
REQ-039 SET_WADDR 14'h1234, then DATA_WR data=5A len=0, then SET_RADDR 1234, then DATA_RD len=0 against a VDP model -> wr bytes 34,52,5A,34,12; rsp_valid once with rsp_data=5A.
REQ-040 DATA_WR data=00 len=255 -> exactly 256 wr pulses with mode=0, then IDLE.
REQ-041 STAT_RD with VDP status 8'h80 -> rd high 4 cycles, mode=1, rsp_data=80, single rsp_valid.
REQ-042 reset=0 one cycle after the first SET_WADDR pulse -> wr/rd low immediately, no second pulse; after release, REG_WR 7,F4 executes normally.
REQ-043 cmd_op=6 -> cmd_err pulse, zero wr/rd activity, cmd_ready high 2 cycles after acceptance.
